// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative 2W/W divider between NREQ requesters.
// Optional divider watchdog enabled by defining DIV_ARB_TIMEOUT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a request while the divider reports done
// S_OVF     | winner failed the overflow screen; grant shown, divider unused
// S_ISSUE   | div_start pulse for the latched operands
// S_WAIT_LO | waiting for the divider to drop done (busy)
// S_WAIT_HI | waiting for done to return; result captured on that edge
// S_RESP    | resp_valid strobe with the captured response fields
module div_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 80
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [0:NREQ-1]            req,
  input  logic [0:NREQ*2*WIDTH-1]    req_num,
  input  logic [0:NREQ*WIDTH-1]      req_den,
  output logic [0:NREQ-1]            grant,
  output logic                       resp_valid,
  output logic [IDW-1:0]             resp_id,
  output logic [WIDTH-1:0]           resp_quotient,
  output logic [WIDTH-1:0]           resp_remainder,
  output logic                       resp_overflow,
  output logic                       resp_error,
  output logic                       div_start,
  output logic [0:2*WIDTH-1]         div_numerator,
  output logic [WIDTH-1:0]           div_denominator,
  output logic                       div_abort,
  input  logic                       div_done,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic [WIDTH-1:0]           div_remainder
);

  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT < 1) begin : g_param_chk
    $error("div_arbiter: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_OVF, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_RESP
  } state_t;

  state_t               state, state_nxt;
  logic [IDW-1:0]       ptr, owner, win_idx;
  logic                 win_found, arb_go;
  logic [0:2*WIDTH-1]   sel_num;
  logic [WIDTH-1:0]     sel_den;
  logic                 sel_ovf;
  logic                 tmo_hit;
  logic                 ld_resp, ld_ovf;
  logic [WIDTH-1:0]     ld_q, ld_r;

  // Two passes: first from the pointer upward, then the wrapped-around lower indices.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!win_found && req[j] && j >= int'(ptr)) begin
        win_found = 1'b1;
        win_idx   = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!win_found && req[j] && j < int'(ptr)) begin
        win_found = 1'b1;
        win_idx   = IDW'(j);
      end
    end
  end

  assign arb_go  = (state == S_IDLE) && win_found && div_done;
  assign sel_num = req_num[int'(win_idx)*2*WIDTH +: 2*WIDTH];
  assign sel_den = req_den[int'(win_idx)*WIDTH +: WIDTH];
  // Quotient cannot fit in WIDTH bits once the high word reaches the divisor.
  assign sel_ovf = (sel_den == '0) || (sel_num[0:WIDTH-1] >= sel_den);

  always_comb begin
    state_nxt = state;
    ld_resp   = 1'b0;
    ld_ovf    = 1'b0;
    ld_q      = '0;
    ld_r      = '0;
    case (state)
      S_IDLE:    if (arb_go) state_nxt = sel_ovf ? S_OVF : S_ISSUE;
      S_OVF: begin
        state_nxt = S_RESP;
        ld_resp   = 1'b1;
        ld_ovf    = 1'b1;
      end
      S_ISSUE:   state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (tmo_hit) begin
          state_nxt = S_RESP;
          ld_resp   = 1'b1;
        end else if (!div_done) begin
          state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (div_done) begin
          state_nxt = S_RESP;
          ld_resp   = 1'b1;
          ld_q      = div_quotient;
          ld_r      = div_remainder;
        end else if (tmo_hit) begin
          state_nxt = S_RESP;
          ld_resp   = 1'b1;
        end
      end
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      ptr             <= '0;
      owner           <= '0;
      grant           <= '0;
      div_numerator   <= '0;
      div_denominator <= '0;
      resp_id         <= '0;
      resp_quotient   <= '0;
      resp_remainder  <= '0;
      resp_overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= '0;
      if (arb_go) begin
        grant[win_idx]  <= 1'b1;
        owner           <= win_idx;
        div_numerator   <= sel_num;
        div_denominator <= sel_den;
        ptr             <= (int'(win_idx) == NREQ-1) ? '0 : win_idx + 1'b1;
      end
      if (ld_resp) begin
        resp_id        <= owner;
        resp_quotient  <= ld_q;
        resp_remainder <= ld_r;
        resp_overflow  <= ld_ovf;
      end
    end
  end

  assign resp_valid = (state == S_RESP);
  assign div_start  = (state == S_ISSUE);

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          in_wait, tmo_fire;

  assign in_wait  = (state == S_WAIT_LO) || (state == S_WAIT_HI);
  assign tmo_hit  = in_wait && (tmo_cnt == '0);
  // A result arriving on the terminal cycle takes precedence over the watchdog.
  assign tmo_fire = tmo_hit && !((state == S_WAIT_HI) && div_done);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt    <= '0;
      div_abort  <= 1'b0;
      resp_error <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        tmo_cnt <= TW'(TIMEOUT - 1);
      else if (in_wait && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - 1'b1;
      div_abort <= tmo_fire;
      if (ld_resp)
        resp_error <= tmo_fire;
    end
  end
`else
  assign tmo_hit    = 1'b0;
  assign div_abort  = 1'b0;
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural multi-cycle divider model.
module tb_div_arbiter;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TMO = 80;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [0:N-1]         req;
  logic [0:N*2*W-1]     req_num;
  logic [0:N*W-1]       req_den;
  logic [0:N-1]         grant;
  logic                 resp_valid;
  logic [IDW-1:0]       resp_id;
  logic [W-1:0]         resp_quotient, resp_remainder;
  logic                 resp_overflow, resp_error;
  logic                 div_start;
  logic [0:2*W-1]       div_numerator;
  logic [W-1:0]         div_denominator;
  logic                 div_abort;
  logic                 div_done;
  logic [W-1:0]         div_quotient, div_remainder;

  div_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .req(req), .req_num(req_num), .req_den(req_den),
    .grant(grant), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .resp_overflow(resp_overflow), .resp_error(resp_error), .div_start(div_start),
    .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_abort(div_abort), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clock = ~clock;

  // Divider model: done drops after start, returns m_lat+1 edges later.
  int          m_lat  = 3;
  bit          m_hang = 1'b0;
  int          m_cnt;
  logic [63:0] m_num;
  logic [63:0] m_den;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      div_done      <= 1'b1;
      div_quotient  <= '0;
      div_remainder <= '0;
      m_cnt         <= 0;
    end else if (div_abort) begin
      div_done <= 1'b1;
    end else if (div_start && div_done) begin
      div_done <= 1'b0;
      m_cnt    <= m_lat;
      m_num    <= div_numerator;
      m_den    <= 64'(div_denominator);
    end else if (!div_done && !m_hang) begin
      if (m_cnt == 0) begin
        div_done      <= 1'b1;
        div_quotient  <= W'(m_num / m_den);
        div_remainder <= W'(m_num % m_den);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  bit prev_start = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      if (div_start) begin
        start_cnt++;
        checks++;
        if (!div_done || prev_start) begin
          errors++;
          $display("FAIL div_start_rule: div_done=%0b prev_start=%0b, required done=1 and single-cycle start",
                   div_done, prev_start);
        end
      end
      if (resp_valid) begin
        checks++;
        if (grant != '0) begin
          errors++;
          $display("FAIL grant_resp_overlap: grant=%b with resp_valid, required grant=0", grant);
        end
      end
      prev_start = div_start;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 0);
    chk({tag, "_flags"}, 64'({resp_valid, resp_overflow, resp_error, div_start, div_abort}), 0);
    chk({tag, "_id"}, 64'(resp_id), 0);
    chk({tag, "_q"}, 64'(resp_quotient), 0);
    chk({tag, "_r"}, 64'(resp_remainder), 0);
    chk({tag, "_num"}, 64'(div_numerator), 0);
    chk({tag, "_den"}, 64'(div_denominator), 0);
  endtask

  task automatic set_req(input int id, input logic [63:0] num, input logic [31:0] den);
    req_num[id*2*W +: 2*W] = num;
    req_den[id*W +: W]     = den;
    req[id]                = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_one(input int id, input logic [63:0] num, input logic [31:0] den,
                         input logic [31:0] eq, input logic [31:0] er, input bit eovf);
    int n;
    bit got;
    int st0;
    logic [0:N-1] g_exp;
    @(negedge clock);
    set_req(id, num, den);
    st0 = start_cnt;
    got = 1'b0;
    n   = 0;
    while (!got && n < 100) begin
      @(negedge clock);
      n++;
      if (grant != '0) got = 1'b1;
    end
    chk("grant_seen", 64'(got), 1);
    g_exp     = '0;
    g_exp[id] = 1'b1;
    chk("grant_onehot", 64'(grant), 64'(g_exp));
    req[id] = 1'b0;
    got = 1'b0;
    n   = 0;
    while (!got && n < 400) begin
      @(negedge clock);
      n++;
      if (n == 1) chk("grant_pulse", 64'(grant), 0);
      if (resp_valid) got = 1'b1;
    end
    chk("resp_seen", 64'(got), 1);
    if (got) begin
      chk("resp_id", 64'(resp_id), 64'(id));
      chk("resp_q", 64'(resp_quotient), 64'(eq));
      chk("resp_r", 64'(resp_remainder), 64'(er));
      chk("resp_ovf", 64'(resp_overflow), 64'(eovf));
      chk("resp_err", 64'(resp_error), 0);
      chk("start_count", 64'(start_cnt - st0), eovf ? 0 : 1);
      if (eovf) chk("ovf_latency", 64'(n), 1);
    end
  endtask

  typedef struct {
    int          id;
    logic [63:0] num;
    logic [31:0] den;
    logic [31:0] q;
    logic [31:0] r;
    bit          ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int gord[$];
    int rid[$];
    logic [31:0] rq[$];
    logic [31:0] rr[$];
    int cnt_v, cnt_a, st_n, rs_n;
    bit got;

    vecs[0] = '{0, 64'd3550, 32'd113, 32'd31, 32'd47, 1'b0};
    vecs[1] = '{1, 64'd100, 32'd17, 32'd5, 32'd15, 1'b0};
    vecs[2] = '{2, 64'd100, 32'd16, 32'd6, 32'd4, 1'b0};
    vecs[3] = '{3, 64'h0000_0005_0000_0007, 32'd5, 32'd0, 32'd0, 1'b1};
    vecs[4] = '{1, 64'd1234, 32'd0, 32'd0, 32'd0, 1'b1};
    vecs[5] = '{2, 64'h0000_0004_FFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd4, 1'b0};
    vecs[6] = '{0, 64'd0, 32'd1, 32'd0, 32'd0, 1'b0};

    reset   = 1'b1;
    req     = '0;
    req_num = '0;
    req_den = '0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_one(vecs[i].id, vecs[i].num, vecs[i].den, vecs[i].q, vecs[i].r, vecs[i].ovf);

    // Round-robin with three simultaneous requesters, pointer starting at 0.
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 64'd3550, 32'd112);
    n = 0;
    while (rid.size() < 3 && n < 600) begin
      @(negedge clock);
      n++;
      for (int i = 0; i < N; i++) if (grant[i]) begin gord.push_back(i); req[i] = 1'b0; end
      if (resp_valid) begin
        rid.push_back(int'(resp_id));
        rq.push_back(resp_quotient);
        rr.push_back(resp_remainder);
      end
    end
    chk("rr_grants", 64'(gord.size()), 3);
    chk("rr_resps", 64'(rid.size()), 3);
    for (int i = 0; i < rid.size(); i++) begin
      if (i < gord.size()) chk("rr_grant_order", 64'(gord[i]), 64'(i));
      chk("rr_resp_id", 64'(rid[i]), 64'(i));
      chk("rr_q", 64'(rq[i]), 31);
      chk("rr_r", 64'(rr[i]), 78);
    end

    // Pointer now sits at 3: requester 3 beats requester 0.
    gord.delete();
    rid.delete();
    set_req(0, 64'd3550, 32'd112);
    set_req(3, 64'd3550, 32'd112);
    n = 0;
    while (rid.size() < 2 && n < 600) begin
      @(negedge clock);
      n++;
      for (int i = 0; i < N; i++) if (grant[i]) begin gord.push_back(i); req[i] = 1'b0; end
      if (resp_valid) rid.push_back(int'(resp_id));
    end
    chk("wrap_grants", 64'(gord.size()), 2);
    if (gord.size() == 2) begin
      chk("wrap_first", 64'(gord[0]), 3);
      chk("wrap_second", 64'(gord[1]), 0);
    end

    // Reset while the arbiter sits in WAIT_HI.
    m_lat = 20;
    @(negedge clock);
    set_req(1, 64'd1000, 32'd3);
    got = 1'b0;
    n   = 0;
    while (!got && n < 100) begin
      @(negedge clock);
      n++;
      if (grant[1]) got = 1'b1;
    end
    chk("wh_grant", 64'(got), 1);
    req[1] = 1'b0;
    n = 0;
    while (div_done && n < 100) begin @(negedge clock); n++; end
    chk("wh_busy", 64'(div_done), 0);
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
    #1 check_all_zero("wh_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cnt_v = 0;
    repeat (40) begin @(negedge clock); if (resp_valid) cnt_v++; end
    chk("wh_no_resp", 64'(cnt_v), 0);
    m_lat = 3;
    run_one(1, 64'd3550, 32'd114, 32'd31, 32'd16, 1'b0);

    // Divider that never finishes.
    m_hang = 1'b1;
    @(negedge clock);
    set_req(2, 64'd5000, 32'd7);
    got = 1'b0;
    n   = 0;
    while (!got && n < 100) begin
      @(negedge clock);
      n++;
      if (grant[2]) got = 1'b1;
    end
    chk("hang_grant", 64'(got), 1);
    req[2] = 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
    got  = 1'b0;
    n    = 0;
    st_n = -1;
    rs_n = -1;
    while (!got && n < 300) begin
      @(negedge clock);
      n++;
      if (div_start) st_n = n;
      if (resp_valid) begin
        got  = 1'b1;
        rs_n = n;
        chk("tmo_abort", 64'(div_abort), 1);
        chk("tmo_error", 64'(resp_error), 1);
        chk("tmo_ovf", 64'(resp_overflow), 0);
        chk("tmo_q", 64'(resp_quotient), 0);
        chk("tmo_r", 64'(resp_remainder), 0);
        chk("tmo_id", 64'(resp_id), 2);
      end
    end
    chk("tmo_resp_seen", 64'(got), 1);
    chk("tmo_latency", 64'(rs_n - st_n), TMO + 1);
`else
    cnt_v = 0;
    cnt_a = 0;
    repeat (300) begin
      @(negedge clock);
      if (resp_valid) cnt_v++;
      if (div_abort) cnt_a++;
    end
    chk("hang_no_resp", 64'(cnt_v), 0);
    chk("hang_no_abort", 64'(cnt_a), 0);
    st_n = 0;
    rs_n = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
